// File: rtl/imm_ctrl.sv
// imm_ctrl: decode-stage immediate controller; classifies opcodes into generator select codes
// and holds up to two decoded entries between IF/ID and ID/EX.
module imm_ctrl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [24:0]      out_imm_val,
    output logic [2:0]       out_imm_sel,
    output logic             out_uses_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [1:0] FULL = 2'(DEPTH);
    logic [31:0]      instr_q [2];
    logic [2:0]       sel_q [2];
    logic [1:0]       uses_q, ill_q;
    logic             wr_q, rd_q;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] stall_q;
    logic [2:0]       dec_sel, f3;
    logic             dec_uses, dec_ill, push, pop, hd;

    always_comb begin
        dec_sel  = 3'd0;
        dec_uses = 1'b0;
        dec_ill  = 1'b0;
        f3       = in_instr[14:12];
        case (in_instr[6:0])
            7'b0000011: dec_uses = 1'b1;
            7'b0010011: begin
                dec_sel  = (f3 == 3'b001 || f3 == 3'b101) ? 3'd1 : 3'd0;
                dec_uses = 1'b1;
            end
            7'b0100011: begin
                dec_sel  = 3'd2;
                dec_uses = 1'b1;
            end
            7'b1100011: dec_sel = 3'd3;
            7'b0110111, 7'b0010111: begin
                dec_sel  = 3'd4;
                dec_uses = 1'b1;
            end
            // link address PC+4: the generator returns constant 4 for this select
            7'b1101111, 7'b1100111: begin
                dec_sel  = 3'd5;
                dec_uses = 1'b1;
            end
            7'b0110011, 7'b0001111, 7'b1110011: dec_uses = 1'b0;
            default: dec_ill = 1'b1;
        endcase
    end

    assign in_ready  = rst && (count_q != FULL);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count_d   = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
    // when empty, keep showing the most recently popped slot
    assign hd        = out_valid ? rd_q : ~rd_q;

    assign out_instr    = instr_q[hd];
    assign out_imm_val  = instr_q[hd][31:7];
    assign out_imm_sel  = sel_q[hd];
    assign out_uses_imm = uses_q[hd];
    assign out_illegal  = ill_q[hd];
    assign stall_cnt    = stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= 2'd0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            stall_q    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            sel_q[0]   <= '0;
            sel_q[1]   <= '0;
            uses_q     <= '0;
            ill_q      <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= flush ? 1'b0 : wr_q ^ push;
            rd_q    <= flush ? 1'b0 : rd_q ^ pop;
            if (push) begin
                instr_q[wr_q] <= in_instr;
                sel_q[wr_q]   <= dec_sel;
                uses_q[wr_q]  <= dec_uses;
                ill_q[wr_q]   <= dec_ill;
            end
            if (out_valid && !out_ready && !flush && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_ctrl.sv
// tb_imm_ctrl: table-driven decode checks plus directed back-pressure, flush, reset and
// counter-saturation sequences.
module tb_imm_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0, flush = 0, out_ready = 0;
    logic [31:0] in_instr = 0;
    logic        in_ready, out_valid, out_uses_imm, out_illegal;
    logic [31:0] out_instr;
    logic [24:0] out_imm_val;
    logic [2:0]  out_imm_sel;
    logic [15:0] stall_cnt;
    logic        in_ready4, out_valid4, out_uses_imm4, out_illegal4;
    logic [31:0] out_instr4;
    logic [24:0] out_imm_val4;
    logic [2:0]  out_imm_sel4;
    logic [3:0]  stall_cnt4;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic        uses;
        logic        ill;
    } vec_t;

    always #5 clk = ~clk;

    imm_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm_val(out_imm_val), .out_imm_sel(out_imm_sel), .out_uses_imm(out_uses_imm),
        .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    imm_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready4),
        .flush(flush), .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
        .out_imm_val(out_imm_val4), .out_imm_sel(out_imm_sel4), .out_uses_imm(out_uses_imm4),
        .out_illegal(out_illegal4), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[14];
        vecs[0]  = '{32'h00500093, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{32'h4030D093, 3'd1, 1'b1, 1'b0};
        vecs[2]  = '{32'h0020A423, 3'd2, 1'b1, 1'b0};
        vecs[3]  = '{32'h00208463, 3'd3, 1'b0, 1'b0};
        vecs[4]  = '{32'h12345037, 3'd4, 1'b1, 1'b0};
        vecs[5]  = '{32'h008000EF, 3'd5, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000007F, 3'd0, 1'b0, 1'b1};
        vecs[7]  = '{32'h00002003, 3'd0, 1'b1, 1'b0};
        vecs[8]  = '{32'h00001017, 3'd4, 1'b1, 1'b0};
        vecs[9]  = '{32'h000080E7, 3'd5, 1'b1, 1'b0};
        vecs[10] = '{32'h002081B3, 3'd0, 1'b0, 1'b0};
        vecs[11] = '{32'h00109093, 3'd1, 1'b1, 1'b0};
        vecs[12] = '{32'h0000000F, 3'd0, 1'b0, 1'b0};
        vecs[13] = '{32'h00000073, 3'd0, 1'b0, 1'b0};

        // reset state
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_imm_val", 32'(out_imm_val), 0);
        check("rst_sel", 32'(out_imm_sel), 0);
        check("rst_uses", 32'(out_uses_imm), 0);
        check("rst_ill", 32'(out_illegal), 0);
        check("rst_stall", 32'(stall_cnt), 0);
        rst = 1;
        #1;
        check("rel_in_ready", 32'(in_ready), 1);

        // decode table streamed at full throughput
        out_ready = 1;
        in_valid  = 1;
        for (int i = 0; i < 14; i++) begin
            in_instr = vecs[i].instr;
            step();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
            check($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
            check($sformatf("v%0d_imm_val", i), 32'(out_imm_val), 32'(vecs[i].instr >> 7));
            check($sformatf("v%0d_sel", i), 32'(out_imm_sel), 32'(vecs[i].sel));
            check($sformatf("v%0d_uses", i), 32'(out_uses_imm), 32'(vecs[i].uses));
            check($sformatf("v%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
            if (i == 0) check("addi_imm_val", 32'(out_imm_val), 32'h000A001);
        end
        in_valid = 0;
        step();
        check("drain_valid", 32'(out_valid), 0);
        check("stream_stall", 32'(stall_cnt), 0);

        // back-pressure: A, B accepted, C held
        out_ready = 0;
        in_valid  = 1;
        in_instr  = 32'h00100113;
        step();
        check("bp_a_valid", 32'(out_valid), 1);
        check("bp_a_in_ready", 32'(in_ready), 1);
        check("bp_a_head", out_instr, 32'h00100113);
        in_instr = 32'h00200193;
        step();
        check("bp_b_in_ready", 32'(in_ready), 0);
        check("bp_b_head", out_instr, 32'h00100113);
        check("bp_b_stall", 32'(stall_cnt), 1);
        in_instr = 32'h00300213;
        step();
        check("bp_c_in_ready", 32'(in_ready), 0);
        check("bp_c_head", out_instr, 32'h00100113);
        check("bp_c_stall", 32'(stall_cnt), 2);
        step();
        check("bp_c2_stall", 32'(stall_cnt), 3);
        out_ready = 1;
        step();
        check("bp_pop1_in_ready", 32'(in_ready), 1);
        check("bp_pop1_head", out_instr, 32'h00200193);
        check("bp_pop1_stall", 32'(stall_cnt), 3);
        step();
        check("bp_pop2_head", out_instr, 32'h00300213);
        check("bp_pop2_valid", 32'(out_valid), 1);
        in_valid = 0;
        step();
        check("bp_empty", 32'(out_valid), 0);
        check("bp_final_stall", 32'(stall_cnt), 3);

        // flush with a full buffer and a valid input
        out_ready = 0;
        in_valid  = 1;
        in_instr  = 32'h00400293;
        step();
        in_instr = 32'h00500313;
        step();
        check("fl_full", 32'(in_ready), 0);
        check("fl_pre_stall", 32'(stall_cnt), 4);
        in_instr = 32'h00600393;
        flush    = 1;
        step();
        flush    = 0;
        in_valid = 0;
        check("fl_valid", 32'(out_valid), 0);
        check("fl_in_ready", 32'(in_ready), 1);
        check("fl_stall", 32'(stall_cnt), 4);
        step();
        check("fl_still_empty", 32'(out_valid), 0);
        out_ready = 1;
        in_valid  = 1;
        in_instr  = 32'h00700413;
        step();
        in_valid = 0;
        check("fl_push_valid", 32'(out_valid), 1);
        check("fl_push_head", out_instr, 32'h00700413);
        step();
        check("fl_push_drained", 32'(out_valid), 0);

        // reset mid-stream with a full buffer
        out_ready = 0;
        in_valid  = 1;
        in_instr  = 32'h00800493;
        step();
        in_instr = 32'h00900513;
        step();
        check("rs_full", 32'(in_ready), 0);
        in_instr = 32'h00A00593;
        rst = 0;
        step();
        check("rs_in_ready", 32'(in_ready), 0);
        check("rs_valid", 32'(out_valid), 0);
        check("rs_instr", out_instr, 0);
        check("rs_sel", 32'(out_imm_sel), 0);
        check("rs_stall", 32'(stall_cnt), 0);
        rst      = 1;
        in_valid = 0;
        #1;
        check("rs_rel_in_ready", 32'(in_ready), 1);
        step();
        check("rs_rel_valid", 32'(out_valid), 0);
        check("rs_rel_stall", 32'(stall_cnt), 0);

        // saturation: 4-bit counter tops out at 15
        in_valid = 1;
        in_instr = 32'h00B00613;
        step();
        in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        check("sat_main_stall", 32'(stall_cnt), 20);
        check("sat_cnt4", 32'(stall_cnt4), 15);
        step();
        check("sat_cnt4_hold", 32'(stall_cnt4), 15);
        check("sat_head", out_instr, 32'h00B00613);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
